// File: rtl/riscv_151_if.sv
`default_nettype none
// ============================================================================
// Module  : riscv_151_if
// Brief   : Word-memory bus with one combinational read port and one
//           byte-enabled synchronous write port.
// Revision: 1.0
// ============================================================================
interface riscv_151_if;
    logic [31:0] raddr;
    logic [31:0] rdata;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wbe;

    modport master (output raddr, waddr, wdata, wbe, input rdata);
    modport slave  (input raddr, waddr, wdata, wbe, output rdata);
endinterface
`default_nettype wire

// File: rtl/riscv_151.sv
`default_nettype none
// ============================================================================
// Module  : riscv_151 (with riscv_151_mem)
// Brief   : Single-cycle RV32I core with internal IMEM/DMEM and tohost CSR.
// Revision: 1.0
// ============================================================================
module riscv_151_mem #(
    parameter int MEM_DEPTH = 16384
) (
    input  wire logic  clk,
    riscv_151_if.slave bus
);
    localparam int c_AW = $clog2(MEM_DEPTH);

    logic [31:0]     mem [0:MEM_DEPTH-1];
    logic [c_AW-1:0] w_ridx;
    logic [c_AW-1:0] w_widx;

    assign w_ridx    = bus.raddr[c_AW+1:2];
    assign w_widx    = bus.waddr[c_AW+1:2];
    assign bus.rdata = mem[w_ridx];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (bus.wbe[b]) begin
                mem[w_widx][8*b +: 8] <= bus.wdata[8*b +: 8];
            end
        end
    end

    logic w_unused;
    assign w_unused = ^{bus.raddr[31:c_AW+2], bus.raddr[1:0],
                        bus.waddr[31:c_AW+2], bus.waddr[1:0]};
endmodule

module riscv_151 #(
    parameter int          CPU_CLOCK_FREQ = 50_000_000,
    parameter logic [31:0] RESET_PC       = 32'h1000_0000,
    parameter int          MEM_DEPTH      = 16384
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        FPGA_SERIAL_RX,
    output logic             FPGA_SERIAL_TX,
    output logic [31:0]      csr
);
    localparam logic [6:0]  c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0]  c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0]  c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0]  c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0]  c_OPC_OP     = 7'b0110011;
    localparam logic [6:0]  c_OPC_SYSTEM = 7'b1110011;
    localparam logic [11:0] c_CSR_TOHOST = 12'h51E;
    localparam logic [3:0]  c_RGN_DMEM   = 4'h1;
    localparam logic [3:0]  c_RGN_IMEM   = 4'h2;

    riscv_151_if u_imem_bus ();
    riscv_151_if u_dmem_bus ();

    riscv_151_mem #(.MEM_DEPTH(MEM_DEPTH)) imem (.clk(clk), .bus(u_imem_bus.slave));
    riscv_151_mem #(.MEM_DEPTH(MEM_DEPTH)) dmem (.clk(clk), .bus(u_dmem_bus.slave));

    logic [31:0] r_pc;
    logic [31:0] r_csr;
    logic [31:0] r_regs [0:31];

    logic [31:0] w_instr;
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [2:0]  w_f3;
    logic        w_f7b5;
    logic [11:0] w_csr_addr;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic [31:0] w_alu_b;
    logic [31:0] w_alu;
    logic        w_br_taken;
    logic [31:0] w_mem_addr;
    logic [3:0]  w_region;
    logic [3:0]  w_st_be;
    logic [31:0] w_st_data;
    logic        w_is_store;
    logic [31:0] w_ld_word;
    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;
    logic [31:0] w_ld_data;
    logic        w_is_csr;
    logic        w_csr_hit;
    logic [31:0] w_csr_wdata;
    logic        w_rd_we;
    logic [31:0] w_rd_data;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_next;

    assign FPGA_SERIAL_TX = 1'b1;
    assign csr            = r_csr;

    assign w_instr    = u_imem_bus.rdata;
    assign w_opcode   = w_instr[6:0];
    assign w_rd       = w_instr[11:7];
    assign w_f3       = w_instr[14:12];
    assign w_rs1      = w_instr[19:15];
    assign w_rs2      = w_instr[24:20];
    assign w_f7b5     = w_instr[30];
    assign w_csr_addr = w_instr[31:20];

    assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
    assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7], w_instr[30:25],
                      w_instr[11:8], 1'b0};
    assign w_imm_u = {w_instr[31:12], 12'b0};
    assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12], w_instr[20],
                      w_instr[30:21], 1'b0};

    // x0 is never written, so the read mux alone makes it read as zero.
    assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2];

    assign w_alu_b = (w_opcode == c_OPC_OP) ? w_rs2_val : w_imm_i;

    always_comb begin
        w_alu = 32'd0;
        case (w_f3)
            3'b000: w_alu = (w_opcode == c_OPC_OP && w_f7b5) ? w_rs1_val - w_alu_b
                                                             : w_rs1_val + w_alu_b;
            3'b001: w_alu = w_rs1_val << w_alu_b[4:0];
            3'b010: w_alu = {31'd0, $signed(w_rs1_val) < $signed(w_alu_b)};
            3'b011: w_alu = {31'd0, w_rs1_val < w_alu_b};
            3'b100: w_alu = w_rs1_val ^ w_alu_b;
            3'b101: w_alu = w_f7b5 ? 32'($signed(w_rs1_val) >>> w_alu_b[4:0])
                                   : w_rs1_val >> w_alu_b[4:0];
            3'b110: w_alu = w_rs1_val | w_alu_b;
            default: w_alu = w_rs1_val & w_alu_b;
        endcase
    end

    always_comb begin
        w_br_taken = 1'b0;
        case (w_f3)
            3'b000: w_br_taken = (w_rs1_val == w_rs2_val);
            3'b001: w_br_taken = (w_rs1_val != w_rs2_val);
            3'b100: w_br_taken = ($signed(w_rs1_val) <  $signed(w_rs2_val));
            3'b101: w_br_taken = ($signed(w_rs1_val) >= $signed(w_rs2_val));
            3'b110: w_br_taken = (w_rs1_val <  w_rs2_val);
            3'b111: w_br_taken = (w_rs1_val >= w_rs2_val);
            default: w_br_taken = 1'b0;
        endcase
    end

    assign w_mem_addr = w_rs1_val + ((w_opcode == c_OPC_STORE) ? w_imm_s : w_imm_i);
    assign w_region   = w_mem_addr[31:28];

    always_comb begin
        w_st_be   = 4'b0000;
        w_st_data = w_rs2_val;
        case (w_f3)
            3'b000: begin
                w_st_be   = 4'b0001 << w_mem_addr[1:0];
                w_st_data = {4{w_rs2_val[7:0]}};
            end
            3'b001: begin
                w_st_be   = w_mem_addr[1] ? 4'b1100 : 4'b0011;
                w_st_data = {2{w_rs2_val[15:0]}};
            end
            3'b010: w_st_be = 4'b1111;
            default: w_st_be = 4'b0000;
        endcase
    end

    // Memory and register writes are suppressed while the core is held in reset.
    assign w_is_store = rst && (w_opcode == c_OPC_STORE);

    assign u_imem_bus.raddr = r_pc;
    assign u_imem_bus.waddr = w_mem_addr;
    assign u_imem_bus.wdata = w_st_data;
    assign u_imem_bus.wbe   = (w_is_store && w_region == c_RGN_IMEM) ? w_st_be : 4'b0000;

    assign u_dmem_bus.raddr = w_mem_addr;
    assign u_dmem_bus.waddr = w_mem_addr;
    assign u_dmem_bus.wdata = w_st_data;
    assign u_dmem_bus.wbe   = (w_is_store && w_region == c_RGN_DMEM) ? w_st_be : 4'b0000;

    assign w_ld_word = (w_region == c_RGN_DMEM) ? u_dmem_bus.rdata : 32'd0;
    assign w_ld_byte = w_ld_word[{w_mem_addr[1:0], 3'b000} +: 8];
    assign w_ld_half = w_mem_addr[1] ? w_ld_word[31:16] : w_ld_word[15:0];

    always_comb begin
        w_ld_data = w_ld_word;
        case (w_f3)
            3'b000: w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
            3'b001: w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
            3'b100: w_ld_data = {24'd0, w_ld_byte};
            3'b101: w_ld_data = {16'd0, w_ld_half};
            default: w_ld_data = w_ld_word;
        endcase
    end

    assign w_is_csr    = (w_opcode == c_OPC_SYSTEM) && (w_f3 == 3'b001 || w_f3 == 3'b101);
    assign w_csr_hit   = (w_csr_addr == c_CSR_TOHOST);
    assign w_csr_wdata = w_f3[2] ? {27'd0, w_rs1} : w_rs1_val;
    assign w_pc_plus4  = r_pc + 32'd4;

    always_comb begin
        w_rd_we   = 1'b0;
        w_rd_data = 32'd0;
        case (w_opcode)
            c_OPC_LUI:   begin w_rd_we = 1'b1; w_rd_data = w_imm_u;        end
            c_OPC_AUIPC: begin w_rd_we = 1'b1; w_rd_data = r_pc + w_imm_u; end
            c_OPC_JAL,
            c_OPC_JALR:  begin w_rd_we = 1'b1; w_rd_data = w_pc_plus4;     end
            c_OPC_LOAD:  begin w_rd_we = 1'b1; w_rd_data = w_ld_data;      end
            c_OPC_OP,
            c_OPC_OPIMM: begin w_rd_we = 1'b1; w_rd_data = w_alu;          end
            c_OPC_SYSTEM: begin
                w_rd_we   = w_is_csr;
                w_rd_data = w_csr_hit ? r_csr : 32'd0;
            end
            default: w_rd_we = 1'b0;
        endcase
        w_rd_we = w_rd_we && rst && (w_rd != 5'd0);
    end

    always_comb begin
        w_pc_next = w_pc_plus4;
        case (w_opcode)
            c_OPC_JAL:    w_pc_next = r_pc + w_imm_j;
            c_OPC_JALR:   w_pc_next = (w_rs1_val + w_imm_i) & ~32'd1;
            c_OPC_BRANCH: w_pc_next = w_br_taken ? r_pc + w_imm_b : w_pc_plus4;
            default:      w_pc_next = w_pc_plus4;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc  <= RESET_PC;
            r_csr <= 32'd0;
        end else begin
            r_pc <= w_pc_next;
            if (w_is_csr && w_csr_hit) begin
                r_csr <= w_csr_wdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_rd_we) begin
            r_regs[w_rd] <= w_rd_data;
        end
    end

    logic w_unused;
    assign w_unused = ^{FPGA_SERIAL_RX, 32'(CPU_CLOCK_FREQ)};
endmodule
`default_nettype wire

// File: tb/tb_riscv_151.sv
`default_nettype none
// ============================================================================
// Module  : tb_riscv_151
// Brief   : Program-level bench for riscv_151 with a csr result scoreboard.
// Revision: 1.0
// ============================================================================
module tb_riscv_151;
    localparam logic [31:0] c_RESET_PC = 32'h1000_0000;
    localparam int          c_CSR      = 12'h51E;
    localparam logic [6:0]  c_LUI  = 7'b0110111;
    localparam logic [6:0]  c_JALR = 7'b1100111;
    localparam logic [6:0]  c_LOAD = 7'b0000011;
    localparam logic [6:0]  c_OPI  = 7'b0010011;
    localparam logic [6:0]  c_OP   = 7'b0110011;
    localparam logic [6:0]  c_SYS  = 7'b1110011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx  = 1'b1;
    logic        tx;
    logic [31:0] csr;

    riscv_151 #(
        .CPU_CLOCK_FREQ(50_000_000),
        .RESET_PC      (c_RESET_PC),
        .MEM_DEPTH     (16384)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .FPGA_SERIAL_RX(rx),
        .FPGA_SERIAL_TX(tx),
        .csr           (csr)
    );

    riscv_151_if u_mon_if ();
    assign u_mon_if.raddr = dut.u_dmem_bus.raddr;
    assign u_mon_if.rdata = dut.u_dmem_bus.rdata;
    assign u_mon_if.waddr = dut.u_dmem_bus.waddr;
    assign u_mon_if.wdata = dut.u_dmem_bus.wdata;
    assign u_mon_if.wbe   = dut.u_dmem_bus.wbe;

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] q_exp [$];
    logic [31:0] prog  [$];

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                          input int rd, input logic [6:0] op);
        return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
    endfunction

    function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                          input int f3, input int rd);
        return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], c_OP};
    endfunction

    function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
        return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] op);
        return {imm20[19:0], rd[4:0], op};
    endfunction

    function automatic logic [31:0] enc_j(input int imm, input int rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
    endfunction

    task automatic load_and_reset();
        rst = 1'b0;
        for (int i = 0; i < prog.size(); i++) begin
            dut.imem.mem[i] = prog[i];
        end
        repeat (2) @(posedge clk);
        #1;
        check_value("csr_held_in_reset", csr, 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic expect_csr(input string tag, input int budget);
        logic [31:0] exp;
        int          n;
        n = 0;
        while (csr == 32'd0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        exp = q_exp.pop_front();
        check_value(tag, csr, exp);
    endtask

    initial begin
        #1 rst = 1'b0;
        #1;
        check_value("reset_pc", dut.r_pc, c_RESET_PC);
        check_value("reset_csr", csr, 32'd0);
        check_value("tx_idle", {31'd0, tx}, 32'd1);

        // csrwi tohost,1 must land on the first edge after release
        prog = '{enc_i(c_CSR, 1, 5, 0, c_SYS), enc_j(0, 0)};
        q_exp.push_back(32'd1);
        load_and_reset();
        expect_csr("first_edge_csr", 1);

        prog = '{enc_i(-5, 0, 0, 1, c_OPI), enc_i(12'h401, 1, 5, 2, c_OPI),
                 enc_r(0, 1, 0, 3, 3), enc_r(7'h20, 1, 0, 0, 5),
                 enc_r(0, 3, 2, 0, 4), enc_i(c_CSR, 4, 1, 0, c_SYS), enc_j(0, 0)};
        q_exp.push_back(32'hFFFF_FFFE);
        load_and_reset();
        expect_csr("arith_csr", 20);
        check_value("srai_x2", dut.r_regs[2], 32'hFFFF_FFFD);
        check_value("sltu_x3", dut.r_regs[3], 32'd1);
        check_value("sub_x5", dut.r_regs[5], 32'd5);

        prog = '{enc_u(20'h10001, 1, c_LUI), enc_u(20'h80000, 2, c_LUI),
                 enc_i(12'h0FF, 2, 0, 2, c_OPI), enc_s(0, 2, 1, 2),
                 enc_i(0, 1, 0, 3, c_LOAD), enc_i(0, 1, 4, 4, c_LOAD),
                 enc_i(0, 1, 1, 5, c_LOAD), enc_i(0, 1, 5, 6, c_LOAD),
                 enc_i(0, 1, 2, 7, c_LOAD),
                 enc_r(0, 4, 3, 0, 8), enc_r(0, 5, 8, 0, 8),
                 enc_r(0, 6, 8, 0, 8), enc_r(0, 7, 8, 0, 8),
                 enc_i(c_CSR, 8, 1, 0, c_SYS),
                 enc_i(12'h012, 0, 0, 9, c_OPI), enc_s(2, 9, 1, 0),
                 enc_i(0, 1, 2, 10, c_LOAD), enc_i(2, 1, 1, 11, c_LOAD),
                 enc_i(7, 0, 0, 12, c_OPI), enc_i(0, 0, 2, 12, c_LOAD),
                 enc_j(0, 0)};
        q_exp.push_back(32'h8000_03FB);
        load_and_reset();
        expect_csr("mem_sum_csr", 40);
        repeat (10) @(posedge clk);
        #1;
        check_value("lb", dut.r_regs[3], 32'hFFFF_FFFF);
        check_value("lbu", dut.r_regs[4], 32'h0000_00FF);
        check_value("lh", dut.r_regs[5], 32'h0000_00FF);
        check_value("lhu", dut.r_regs[6], 32'h0000_00FF);
        check_value("lw", dut.r_regs[7], 32'h8000_00FF);
        check_value("sb_word", dut.r_regs[10], 32'h8012_00FF);
        check_value("dmem_word", dut.dmem.mem[14'h400], 32'h8012_00FF);
        check_value("lh_upper", dut.r_regs[11], 32'hFFFF_8012);
        check_value("load_unmapped", dut.r_regs[12], 32'd0);

        prog = '{enc_i(0, 0, 0, 1, c_OPI), enc_i(10, 0, 0, 2, c_OPI),
                 enc_i(1, 1, 0, 1, c_OPI), enc_b(-4, 2, 1, 4),
                 enc_b(32, 2, 1, 1), enc_b(8, 2, 1, 7),
                 enc_j(24, 0), enc_j(12, 5), enc_j(0, 0),
                 enc_i(0, 0, 0, 0, c_OPI),
                 enc_i(c_CSR, 1, 5, 0, c_SYS), enc_i(0, 5, 0, 0, c_JALR),
                 enc_i(c_CSR, 3, 5, 0, c_SYS), enc_j(0, 0)};
        q_exp.push_back(32'd1);
        load_and_reset();
        expect_csr("loop_csr", 100);
        repeat (3) @(posedge clk);
        #1;
        check_value("loop_count", dut.r_regs[1], 32'd10);
        check_value("link_reg", dut.r_regs[5], 32'h1000_0020);

        // asynchronous reset between clock edges
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_value("async_rst_csr", csr, 32'd0);
        check_value("async_rst_pc", dut.r_pc, c_RESET_PC);
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_value("midloop_rst_pc", dut.r_pc, c_RESET_PC);
        repeat (2) @(posedge clk);
        #1;
        check_value("rst_hold_pc", dut.r_pc, c_RESET_PC);
        @(negedge clk);
        q_exp.push_back(32'd1);
        rst = 1'b1;
        expect_csr("rerun_csr", 100);
        repeat (3) @(posedge clk);
        #1;
        check_value("rerun_count", dut.r_regs[1], 32'd10);

        // self-test failure code plus CSR read-back and foreign-CSR behaviour
        prog = '{enc_i(9, 0, 0, 7, c_OPI), enc_i(c_CSR, 3, 5, 6, c_SYS),
                 enc_i(12'h340, 0, 1, 7, c_SYS), enc_i(c_CSR, 3, 5, 8, c_SYS),
                 enc_j(0, 0)};
        q_exp.push_back(32'd3);
        load_and_reset();
        expect_csr("fail_code_csr", 20);
        repeat (4) @(posedge clk);
        #1;
        check_value("csr_old_x6", dut.r_regs[6], 32'd0);
        check_value("other_csr_x7", dut.r_regs[7], 32'd0);
        check_value("csr_old_x8", dut.r_regs[8], 32'd3);
        check_value("fail_code_hold", csr, 32'd3);
        check_value("tx_idle_end", {31'd0, tx}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
